// File: rtl/wb_pkg.sv
// ---------------------------------------------------------------------------
// wb_pkg
// Shared definitions for the writeback commit block and its store queue:
//   - operand size encodings (SZ_1B .. SZ_8B)
//   - EIP and register-index widths
//   - store-entry record {addr, data, size} at the default channel widths
//   - popcount helper used to size a multi-channel enqueue
// ---------------------------------------------------------------------------
package wb_pkg;

  localparam logic [1:0] SZ_1B = 2'b00;
  localparam logic [1:0] SZ_2B = 2'b01;
  localparam logic [1:0] SZ_4B = 2'b10;
  localparam logic [1:0] SZ_8B = 2'b11;

  localparam int EIP_W    = 32;
  localparam int REGIDX_W = 3;

  localparam int ENTRY_ADDR_W = 32;
  localparam int ENTRY_DATA_W = 64;

  typedef struct packed {
    logic [ENTRY_ADDR_W-1:0] addr;
    logic [ENTRY_DATA_W-1:0] data;
    logic [1:0]              size;
  } store_entry_t;

  // Callers zero-extend their mask into 32 bits; NUM_CH is far below that.
  function automatic int unsigned popcount(input logic [31:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < 32; i++) begin
      n = n + int'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/wb_store_fifo.sv
// ---------------------------------------------------------------------------
// wb_store_fifo
// Circular store buffer accepting up to NUM_CH entries per cycle and
// releasing one per cycle.
//   clk, rst     clock, synchronous active-high reset (pointers/count only)
//   i_wr_en      enqueue the masked channels this cycle
//   i_wr_mask    which channels carry an entry
//   i_wr_addr    NUM_CH packed addresses
//   i_wr_data    NUM_CH packed data words
//   i_wr_size    size shared by every entry of this enqueue
//   i_rd_en      consumer takes the head entry (ignored when empty)
//   o_valid      head entry present
//   o_addr/o_data/o_size  head entry, zero while empty
//   o_count      occupied entries
//   o_free       DEPTH - o_count
// ---------------------------------------------------------------------------
module wb_store_fifo
  import wb_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 64,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_wr_en,
  input  logic [NUM_CH-1:0]            i_wr_mask,
  input  logic [NUM_CH*ADDR_W-1:0]     i_wr_addr,
  input  logic [NUM_CH*DATA_W-1:0]     i_wr_data,
  input  logic [1:0]                   i_wr_size,
  input  logic                         i_rd_en,
  output logic                         o_valid,
  output logic [ADDR_W-1:0]            o_addr,
  output logic [DATA_W-1:0]            o_data,
  output logic [1:0]                   o_size,
  output logic [$clog2(DEPTH+1)-1:0]   o_count,
  output logic [$clog2(DEPTH+1)-1:0]   o_free
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH+1);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [1:0]        size;
  } entry_t;

  entry_t             r_mem [DEPTH];
  logic [PTR_W-1:0]   r_head;
  logic [PTR_W-1:0]   r_tail;
  logic [CNT_W-1:0]   r_count;

  logic [PTR_W-1:0]   w_slot [NUM_CH];
  logic [CNT_W-1:0]   w_n_wr;
  logic [CNT_W-1:0]   w_cnt_add;
  logic [CNT_W-1:0]   w_cnt_sub;
  logic               w_rd;
  entry_t             w_head;

  // Compaction: each masked channel lands at tail + (number of masked
  // channels below it). DEPTH is a power of two, so pointer overflow is the
  // wrap.
  always_comb begin
    w_n_wr = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_slot[i] = r_tail + w_n_wr[PTR_W-1:0];
      if (i_wr_mask[i]) begin
        w_n_wr = w_n_wr + CNT_W'(1);
      end
    end
  end

  assign o_valid   = (r_count != '0);
  assign w_rd      = i_rd_en & o_valid;
  assign w_cnt_add = i_wr_en ? w_n_wr : '0;
  assign w_cnt_sub = CNT_W'(w_rd);

  // Storage carries no reset; emptiness is tracked by the count alone.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (i_wr_en && i_wr_mask[i]) begin
        r_mem[w_slot[i]] <= '{addr: i_wr_addr[i*ADDR_W +: ADDR_W],
                               data: i_wr_data[i*DATA_W +: DATA_W],
                               size: i_wr_size};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (i_wr_en) begin
        r_tail <= r_tail + w_n_wr[PTR_W-1:0];
      end
      if (w_rd) begin
        r_head <= r_head + PTR_W'(1);
      end
      r_count <= r_count + w_cnt_add - w_cnt_sub;
    end
  end

  // Head is forced to zero while empty so stale slots never reach the port.
  assign w_head  = o_valid ? r_mem[r_head] : '0;
  assign o_addr  = w_head.addr;
  assign o_data  = w_head.data;
  assign o_size  = w_head.size;
  assign o_count = r_count;
  assign o_free  = CNT_W'(DEPTH) - r_count;

endmodule

// File: rtl/wb_commit_queue.sv
// ---------------------------------------------------------------------------
// wb_commit_queue
// Writeback commit stage: decides whether the WB instruction commits, fans
// out GPR write enables, queues all of its memory writes into a store queue
// draining one entry per cycle, keeps a sticky halt latch and a shift
// register of recently committed EIPs.
//   clk, rst              clock, synchronous active-high reset
//   valid_in, ie_in       WB instruction valid / carries interrupt-exception
//   halt_op, eip_in       HLT marker and EIP of the WB instruction
//   ch_data/ch_dest       per-channel result and destination (packed)
//   ch_is_reg/ch_is_mem   per-channel target class
//   ch_wb, ch_size        per-channel write enable, shared operand size
//   mq_ready              memory write port takes the head entry
//   commit, stall         commit decision / hold WB latch
//   reg_ld, reg_addr      per-channel GPR load and index (ch_dest[2:0])
//   mq_valid/addr/data/size/count  store queue head and occupancy
//   halted                sticky halt
//   eip_hist              committed EIPs, slot 0 newest
// ---------------------------------------------------------------------------
module wb_commit_queue
  import wb_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 32,
  parameter int MQ_DEPTH = 4,
  parameter int EIP_HIST = 3
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            valid_in,
  input  logic                            ie_in,
  input  logic                            halt_op,
  input  logic [EIP_W-1:0]                eip_in,
  input  logic [NUM_CH*DATA_W-1:0]        ch_data,
  input  logic [NUM_CH*ADDR_W-1:0]        ch_dest,
  input  logic [NUM_CH-1:0]               ch_is_reg,
  input  logic [NUM_CH-1:0]               ch_is_mem,
  input  logic [NUM_CH-1:0]               ch_wb,
  input  logic [1:0]                      ch_size,
  input  logic                            mq_ready,
  output logic                            commit,
  output logic                            stall,
  output logic [NUM_CH-1:0]               reg_ld,
  output logic [NUM_CH*REGIDX_W-1:0]      reg_addr,
  output logic                            mq_valid,
  output logic [ADDR_W-1:0]               mq_addr,
  output logic [DATA_W-1:0]               mq_data,
  output logic [1:0]                      mq_size,
  output logic [$clog2(MQ_DEPTH+1)-1:0]   mq_count,
  output logic                            halted,
  output logic [EIP_HIST*EIP_W-1:0]       eip_hist
);

  localparam int CNT_W = $clog2(MQ_DEPTH+1);
  localparam int NCH_W = $clog2(NUM_CH+1);

  logic [NUM_CH-1:0] w_mem_req;
  logic [NCH_W-1:0]  w_n_mem;
  logic [CNT_W-1:0]  w_free;
  logic [CNT_W-1:0]  w_count;
  logic              w_act;
  logic              w_no_room;
  logic              w_stall;
  logic              w_commit;

  logic              r_halted;
  logic [EIP_W-1:0]  r_eip [EIP_HIST];

  assign w_mem_req = ch_is_mem & ch_wb;
  assign w_n_mem   = NCH_W'(popcount(32'(w_mem_req)));

  // Room is judged on the registered count only: a dequeue in this same
  // cycle does not make space for this instruction.
  assign w_act     = valid_in & ~ie_in;
  assign w_no_room = (32'(w_n_mem) > 32'(w_free));
  assign w_stall   = w_act & (r_halted | w_no_room);
  assign w_commit  = w_act & ~w_stall;

  assign commit = w_commit;
  assign stall  = w_stall;
  assign reg_ld = {NUM_CH{w_commit}} & ch_is_reg & ch_wb;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_reg_addr
    assign reg_addr[gi*REGIDX_W +: REGIDX_W] = ch_dest[gi*ADDR_W +: REGIDX_W];
  end

  wb_store_fifo #(
    .NUM_CH (NUM_CH),
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (MQ_DEPTH)
  ) u_store_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (w_commit),
    .i_wr_mask (w_mem_req),
    .i_wr_addr (ch_dest),
    .i_wr_data (ch_data),
    .i_wr_size (ch_size),
    .i_rd_en   (mq_ready),
    .o_valid   (mq_valid),
    .o_addr    (mq_addr),
    .o_data    (mq_data),
    .o_size    (mq_size),
    .o_count   (w_count),
    .o_free    (w_free)
  );

  assign mq_count = w_count;

  // Halt only clears on reset; it does not stop the queue from draining.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_halted <= 1'b0;
    end else if (w_commit && halt_op) begin
      r_halted <= 1'b1;
    end
  end

  assign halted = r_halted;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < EIP_HIST; k++) begin
        r_eip[k] <= '0;
      end
    end else if (w_commit) begin
      for (int k = EIP_HIST-1; k > 0; k--) begin
        r_eip[k] <= r_eip[k-1];
      end
      r_eip[0] <= eip_in;
    end
  end

  for (genvar gk = 0; gk < EIP_HIST; gk++) begin : g_eip_hist
    assign eip_hist[gk*EIP_W +: EIP_W] = r_eip[gk];
  end

endmodule

// File: tb/tb_wb_commit_queue.sv
module tb_wb_commit_queue;
  import wb_pkg::*;

  localparam int NUM_CH   = 4;
  localparam int DATA_W   = 64;
  localparam int ADDR_W   = 32;
  localparam int MQ_DEPTH = 4;
  localparam int EIP_HIST = 3;
  localparam int CNT_W    = $clog2(MQ_DEPTH+1);

  logic                        clk = 1'b0;
  logic                        rst;
  logic                        valid_in, ie_in, halt_op;
  logic [31:0]                 eip_in;
  logic [NUM_CH*DATA_W-1:0]    ch_data;
  logic [NUM_CH*ADDR_W-1:0]    ch_dest;
  logic [NUM_CH-1:0]           ch_is_reg, ch_is_mem, ch_wb;
  logic [1:0]                  ch_size;
  logic                        mq_ready;
  logic                        commit, stall;
  logic [NUM_CH-1:0]           reg_ld;
  logic [NUM_CH*3-1:0]         reg_addr;
  logic                        mq_valid;
  logic [ADDR_W-1:0]           mq_addr;
  logic [DATA_W-1:0]           mq_data;
  logic [1:0]                  mq_size;
  logic [CNT_W-1:0]            mq_count;
  logic                        halted;
  logic [EIP_HIST*32-1:0]      eip_hist;

  always #5 clk = ~clk;

  wb_commit_queue #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .ADDR_W(ADDR_W),
    .MQ_DEPTH(MQ_DEPTH), .EIP_HIST(EIP_HIST)
  ) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .ie_in(ie_in),
    .halt_op(halt_op), .eip_in(eip_in), .ch_data(ch_data),
    .ch_dest(ch_dest), .ch_is_reg(ch_is_reg), .ch_is_mem(ch_is_mem),
    .ch_wb(ch_wb), .ch_size(ch_size), .mq_ready(mq_ready),
    .commit(commit), .stall(stall), .reg_ld(reg_ld), .reg_addr(reg_addr),
    .mq_valid(mq_valid), .mq_addr(mq_addr), .mq_data(mq_data),
    .mq_size(mq_size), .mq_count(mq_count), .halted(halted),
    .eip_hist(eip_hist)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: a plain queue of stores, a halt flag, an EIP array.
  store_entry_t mq_m[$];
  logic         m_halt;
  logic [31:0]  m_eip [EIP_HIST];
  logic         m_commit;

  typedef struct {
    logic       valid, ie, halt;
    logic [3:0] is_mem, is_reg, wb;
    logic       e_commit, e_stall;
    logic [3:0] e_reg_ld;
  } vec_t;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic set_ch(input int i, input logic [31:0] a, input logic [63:0] d);
    ch_dest[i*ADDR_W +: ADDR_W] = a;
    ch_data[i*DATA_W +: DATA_W] = d;
  endtask

  task automatic clear_in();
    valid_in = 0; ie_in = 0; halt_op = 0; eip_in = '0;
    ch_data = '0; ch_dest = '0; ch_is_reg = '0; ch_is_mem = '0; ch_wb = '0;
    ch_size = 2'b00; mq_ready = 0;
  endtask

  task automatic model_check();
    int          n;
    int          room;
    logic        e_stall;
    logic [95:0] e_eip;
    n       = $countones(ch_is_mem & ch_wb);
    room    = MQ_DEPTH - mq_m.size();
    e_stall = valid_in & ~ie_in & (m_halt | (n > room));
    m_commit = valid_in & ~ie_in & ~e_stall;
    chk("m_stall", 128'(stall), 128'(e_stall));
    chk("m_commit", 128'(commit), 128'(m_commit));
    chk("m_reg_ld", 128'(reg_ld), 128'(m_commit ? (ch_is_reg & ch_wb) : 4'b0));
    chk("m_count", 128'(mq_count), 128'(mq_m.size()));
    chk("m_valid", 128'(mq_valid), 128'(mq_m.size() != 0));
    if (mq_m.size() != 0) begin
      chk("m_addr", 128'(mq_addr), 128'(mq_m[0].addr));
      chk("m_data", 128'(mq_data), 128'(mq_m[0].data));
      chk("m_size", 128'(mq_size), 128'(mq_m[0].size));
    end
    chk("m_halted", 128'(halted), 128'(m_halt));
    for (int k = 0; k < EIP_HIST; k++) e_eip[k*32 +: 32] = m_eip[k];
    chk("m_eip_hist", 128'(eip_hist), 128'(e_eip));
  endtask

  task automatic model_update();
    store_entry_t e;
    if (rst) begin
      mq_m.delete();
      m_halt = 0;
      for (int k = 0; k < EIP_HIST; k++) m_eip[k] = '0;
    end else begin
      if (mq_m.size() != 0 && mq_ready) void'(mq_m.pop_front());
      if (m_commit) begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (ch_is_mem[i] && ch_wb[i]) begin
            e.addr = ch_dest[i*ADDR_W +: ADDR_W];
            e.data = ch_data[i*DATA_W +: DATA_W];
            e.size = ch_size;
            mq_m.push_back(e);
          end
        end
        if (halt_op) m_halt = 1;
        for (int k = EIP_HIST-1; k > 0; k--) m_eip[k] = m_eip[k-1];
        m_eip[0] = eip_in;
      end
    end
  endtask

  // Inputs are driven 1 time unit after the rising edge; checks run 1 unit later.
  task automatic step();
    model_check();
    model_update();
    @(posedge clk);
    #1;
  endtask

  vec_t vecs [7];

  initial begin
    vecs[0] = '{1,0,0, 4'b0000, 4'b0011, 4'b0011, 1,0, 4'b0011};
    vecs[1] = '{0,0,0, 4'b0000, 4'b0011, 4'b0011, 0,0, 4'b0000};
    vecs[2] = '{1,1,0, 4'b0000, 4'b1111, 4'b1111, 0,0, 4'b0000};
    vecs[3] = '{1,0,0, 4'b1111, 4'b0000, 4'b1111, 1,0, 4'b0000};
    vecs[4] = '{1,0,0, 4'b0000, 4'b1010, 4'b1000, 1,0, 4'b1000};
    vecs[5] = '{1,0,0, 4'b0101, 4'b1010, 4'b1111, 1,0, 4'b1010};
    vecs[6] = '{1,1,0, 4'b1111, 4'b0000, 4'b1111, 0,0, 4'b0000};

    clear_in();
    rst = 1;
    m_commit = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    model_update();
    rst = 0;
    #1;
    chk("rst_count", 128'(mq_count), 128'(0));
    chk("rst_valid", 128'(mq_valid), 128'(0));
    chk("rst_addr", 128'(mq_addr), 128'(0));
    chk("rst_data", 128'(mq_data), 128'(0));
    chk("rst_size", 128'(mq_size), 128'(0));
    chk("rst_halted", 128'(halted), 128'(0));
    chk("rst_eip", 128'(eip_hist), 128'(0));

    // Table: each vector is applied with rst high so it sees an empty queue.
    for (int v = 0; v < 7; v++) begin
      clear_in();
      rst = 1;
      for (int i = 0; i < NUM_CH; i++) set_ch(i, 32'h100*(i+1) + i + 5, 64'(i));
      valid_in = vecs[v].valid; ie_in = vecs[v].ie; halt_op = vecs[v].halt;
      ch_is_mem = vecs[v].is_mem; ch_is_reg = vecs[v].is_reg; ch_wb = vecs[v].wb;
      #1;
      chk($sformatf("tbl%0d_commit", v), 128'(commit), 128'(vecs[v].e_commit));
      chk($sformatf("tbl%0d_stall", v), 128'(stall), 128'(vecs[v].e_stall));
      chk($sformatf("tbl%0d_reg_ld", v), 128'(reg_ld), 128'(vecs[v].e_reg_ld));
      chk($sformatf("tbl%0d_reg_addr", v), 128'(reg_addr), 128'(12'b000_111_110_101));
      step();
    end
    rst = 0;

    // Two stores from channels 1 and 3, then drain in channel order.
    clear_in();
    valid_in = 1; ch_is_mem = 4'b1010; ch_wb = 4'b1010; ch_size = 2'b10;
    set_ch(1, 32'h100, 64'hA); set_ch(3, 32'h200, 64'hB);
    #1;
    chk("s1_commit", 128'(commit), 128'(1));
    chk("s1_not_yet_visible", 128'(mq_valid), 128'(0));
    step();
    clear_in();
    #1;
    chk("s1_count", 128'(mq_count), 128'(2));
    chk("s1_head0", 128'(mq_addr), 128'(32'h100));
    chk("s1_size", 128'(mq_size), 128'(2'b10));
    mq_ready = 1;
    step();
    chk("s1_head1", 128'(mq_addr), 128'(32'h200));
    chk("s1_data1", 128'(mq_data), 128'(64'hB));
    step();
    chk("s1_empty", 128'(mq_valid), 128'(0));

    // Stall on insufficient room, release after one dequeue, fill to 4.
    clear_in();
    valid_in = 1; ch_is_mem = 4'b0111; ch_wb = 4'b0111;
    set_ch(0, 32'h300, 64'h1); set_ch(1, 32'h304, 64'h2); set_ch(2, 32'h308, 64'h3);
    #1;
    step();
    ch_is_mem = 4'b0011; ch_wb = 4'b0011;
    set_ch(0, 32'h400, 64'h4); set_ch(1, 32'h404, 64'h5);
    #1;
    chk("s2_count3", 128'(mq_count), 128'(3));
    chk("s2_stall", 128'(stall), 128'(1));
    chk("s2_no_commit", 128'(commit), 128'(0));
    step();
    mq_ready = 1;
    #1;
    chk("s2_no_bypass_stall", 128'(stall), 128'(1));
    step();
    mq_ready = 0;
    #1;
    chk("s2_count2", 128'(mq_count), 128'(2));
    chk("s2_commit", 128'(commit), 128'(1));
    step();
    ch_is_mem = 4'b0001; ch_wb = 4'b0001;
    #1;
    chk("s2_full", 128'(mq_count), 128'(4));
    chk("s2_full_stall", 128'(stall), 128'(1));
    step();
    clear_in();
    mq_ready = 1;
    #1;
    chk("s2_order0", 128'(mq_addr), 128'(32'h304));
    step();
    chk("s2_order1", 128'(mq_addr), 128'(32'h308));
    step();
    chk("s2_order2", 128'(mq_addr), 128'(32'h400));
    step();
    chk("s2_order3", 128'(mq_addr), 128'(32'h404));
    step();
    chk("s2_drained", 128'(mq_count), 128'(0));

    // Enqueue into an empty queue with mq_ready high: no phantom dequeue.
    clear_in();
    valid_in = 1; ch_is_mem = 4'b0100; ch_wb = 4'b0100; mq_ready = 1;
    set_ch(2, 32'h500, 64'h77);
    #1;
    step();
    clear_in();
    #1;
    chk("s3_count1", 128'(mq_count), 128'(1));
    chk("s3_head", 128'(mq_addr), 128'(32'h500));
    mq_ready = 1;
    step();

    // Exception suppresses everything.
    clear_in();
    rst = 1;
    #1;
    step();
    rst = 0;
    valid_in = 1; eip_in = 32'h40; ch_is_mem = 4'b0001; ch_wb = 4'b0001;
    set_ch(0, 32'h600, 64'h9);
    #1;
    step();
    valid_in = 1; ie_in = 1; eip_in = 32'h44;
    ch_is_reg = 4'b0011; ch_is_mem = 4'b1100; ch_wb = 4'b1111;
    #1;
    chk("s4_commit", 128'(commit), 128'(0));
    chk("s4_stall", 128'(stall), 128'(0));
    chk("s4_reg_ld", 128'(reg_ld), 128'(0));
    step();
    clear_in();
    #1;
    chk("s4_count", 128'(mq_count), 128'(1));
    chk("s4_eip", 128'(eip_hist), 128'(96'h40));

    // EIP history and halt; reset while halted mid-drain.
    clear_in();
    rst = 1;
    #1;
    step();
    rst = 0;
    for (int j = 0; j < 3; j++) begin
      clear_in();
      valid_in = 1; eip_in = 32'h10 + 32'(4*j);
      ch_is_mem = 4'b0001; ch_wb = 4'b0001; set_ch(0, 32'h700 + 32'(j), 64'(j));
      #1;
      step();
    end
    clear_in();
    valid_in = 1; eip_in = 32'h1C; halt_op = 1;
    #1;
    step();
    clear_in();
    valid_in = 1; eip_in = 32'h20;
    #1;
    chk("s5_eip", 128'(eip_hist), 128'({32'h14, 32'h18, 32'h1C}));
    chk("s5_halted", 128'(halted), 128'(1));
    chk("s5_count3", 128'(mq_count), 128'(3));
    chk("s5_stall", 128'(stall), 128'(1));
    step();
    chk("s5_stall_again", 128'(stall), 128'(1));
    step();
    rst = 1; mq_ready = 1;
    #1;
    step();
    rst = 0;
    clear_in();
    #1;
    chk("s6_count", 128'(mq_count), 128'(0));
    chk("s6_valid", 128'(mq_valid), 128'(0));
    chk("s6_halted", 128'(halted), 128'(0));
    chk("s6_eip", 128'(eip_hist), 128'(0));

    // Halting instruction that also stores; queue drains while halted.
    valid_in = 1; halt_op = 1; eip_in = 32'h80; ch_is_mem = 4'b0011; ch_wb = 4'b0011;
    set_ch(0, 32'h800, 64'h1); set_ch(1, 32'h804, 64'h2);
    #1;
    step();
    clear_in();
    valid_in = 1; mq_ready = 1;
    #1;
    chk("s7_halted", 128'(halted), 128'(1));
    chk("s7_count2", 128'(mq_count), 128'(2));
    step();
    chk("s7_count1", 128'(mq_count), 128'(1));
    chk("s7_stall", 128'(stall), 128'(1));
    step();
    chk("s7_count0", 128'(mq_count), 128'(0));
    chk("s7_stall_end", 128'(stall), 128'(1));
    step();

    // Randomized traffic against the model.
    for (int c = 0; c < 600; c++) begin
      rst      = ($urandom_range(0, 39) == 0);
      valid_in = ($urandom_range(0, 3) != 0);
      ie_in    = ($urandom_range(0, 7) == 0);
      halt_op  = ($urandom_range(0, 39) == 0);
      eip_in   = $urandom;
      ch_is_mem = 4'($urandom);
      ch_is_reg = 4'($urandom);
      ch_wb     = 4'($urandom);
      ch_size   = 2'($urandom);
      mq_ready  = ($urandom_range(0, 2) != 0);
      for (int i = 0; i < NUM_CH; i++) set_ch(i, $urandom, {$urandom, $urandom});
      #1;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_commit_queue.md
Name: wb_commit_queue

Overview:
- Parametrised next-generation writeback commit block with NUM_CH result channels.
- Decides per cycle whether the instruction in WB commits.
- Fans out register write enables.
- Buffers all memory writes from one instruction in an internal multi-enqueue store queue that drains one entry per cycle to the memory write port.
- Also holds a sticky halt latch and a configurable-depth committed-EIP history.
- Sits between the execute/WB latch and the register file, segment file and data-cache write path.

Parameters:
- NUM_CH, 4, number of result channels per instruction
- DATA_W, 64, channel data width
- ADDR_W, 32, channel destination / memory address width
- MQ_DEPTH, 4, store queue entries; power of two, >= NUM_CH
- EIP_HIST, 3, depth of committed-EIP history

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- valid_in  in  1  WB instruction valid
- ie_in  in  1  instruction carries an interrupt/exception; suppresses commit
- halt_op  in  1  instruction is HLT
- eip_in  in  32  EIP of the WB instruction
- ch_data  in  NUM_CH*DATA_W  channel results; channel i occupies [i*DATA_W +: DATA_W]
- ch_dest  in  NUM_CH*ADDR_W  channel destination; register/segment index in bits [2:0]
- ch_is_reg  in  NUM_CH  channel targets the GPR file
- ch_is_mem  in  NUM_CH  channel targets memory
- ch_wb  in  NUM_CH  channel write enable
- ch_size  in  2  operand size (00=1B, 01=2B, 10=4B, 11=8B)
- mq_ready  in  1  memory write port accepts the head entry this cycle
- commit  out  1  instruction commits this cycle
- stall  out  1  hold WB latch
- reg_ld  out  NUM_CH  per-channel GPR load
- reg_addr  out  NUM_CH*3  per-channel ch_dest[2:0]
- mq_valid  out  1  queue head valid
- mq_addr  out  ADDR_W  head address
- mq_data  out  DATA_W  head data
- mq_size  out  2  head size
- mq_count  out  clog2(MQ_DEPTH+1)  occupied entries
- halted  out  1  sticky halt
- eip_hist  out  EIP_HIST*32  committed EIPs; slot 0 is the newest

Behaviour:
- Combinational signals:
  - mem_req[i] = ch_is_mem[i] & ch_wb[i].
  - n_mem = popcount(mem_req).
  - free = MQ_DEPTH - mq_count. This uses the registered count only; there is no bypass from a same-cycle dequeue.
  - stall = valid_in & ~ie_in & (halted | (n_mem > free)).
  - commit = valid_in & ~ie_in & ~stall.
  - reg_ld[i] = commit & ch_is_reg[i] & ch_wb[i]. reg_addr is pure passthrough.
- ie_in=1 forces commit=0, stall=0, no enqueue and no history update. The trap logic flushes the WB latch; this block holds nothing for it.
- Enqueue: on commit, all mem_req channels are written in the same cycle, in ascending channel index order, into consecutive slots starting at the tail. Every entry takes size = ch_size. Tail wraps modulo MQ_DEPTH.
- Dequeue:
  - mq_valid = (mq_count != 0).
  - When mq_valid & mq_ready, head advances by one, wrapping modulo MQ_DEPTH.
  - mq_addr/mq_data/mq_size are the registered head entry, stable while mq_ready=0.
- Same-cycle enqueue and dequeue: mq_count_next = mq_count + n_mem(if commit) - (mq_valid & mq_ready).
- Full queue: mq_count is never allowed to exceed MQ_DEPTH. This is guaranteed by the stall rule.
- Halt:
  - A commit with halt_op=1 sets halted at the next edge.
  - halted stays at 1 until rst.
  - While halted, every valid instruction stalls. The queue keeps draining.
- EIP history: on commit, eip_hist shifts by one slot and eip_in enters slot 0.
- Latency: enqueued data is visible on mq_* no earlier than the cycle after commit.
- Reset (synchronous, overrides all same-cycle events, including mid-drain):
  - head=tail=0, mq_count=0, mq_valid=0.
  - mq_addr/mq_data/mq_size=0.
  - halted=0, eip_hist=0.
  - Combinational outputs follow their inputs.

Decomposition:
- Shared package wb_pkg:
  - size-encoding constants SZ_1B..SZ_8B
  - EIP_W=32, REGIDX_W=3
  - store-entry typedef {addr, data, size}
- Sub-module wb_store_fifo:
  - circular buffer with up to NUM_CH writes per cycle (write mask plus compaction by prefix count) and one read
  - exposes count, head entry and free
- Top level holds the commit/stall logic, halt latch and EIP shift register.

Test Plan:
- Defaults, reset, then valid_in=1 with channels 1 and 3 as mem writes (addr 0x100/0x200, data 0xA/0xB), size 10, mq_ready=0 -> commit=1, next cycle mq_count=2, head addr 0x100; with mq_ready=1 -> 0x100 then 0x200, then mq_valid=0.
- mq_count=3 with mq_ready=0, instruction with 2 mem writes -> stall=1, commit=0. Raise mq_ready for one cycle -> count 2, the same instruction then commits, count becomes 4 (full), and no overflow occurs.
- Empty queue, commit of 1 mem write while mq_ready=1 -> no phantom dequeue; count=1 next cycle.
- ie_in=1 with reg and mem channels -> commit=0, stall=0, reg_ld=0000, mq_count and eip_hist unchanged.
- Commits at EIP 0x10, 0x14, 0x18, then halt_op commit at 0x1C -> eip_hist={0x14,0x18,0x1C} (slot0=0x1C), halted=1. The next valid instruction stalls indefinitely while queued stores still drain.
- rst while mq_count=3 and halted=1 -> next cycle mq_count=0, mq_valid=0, halted=0, eip_hist=0.
